// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields (opcode, registers, funct, 12-bit
// immediate) into 32-bit instruction words. The words are streamed to
// instruction memory over valid/ready, together with a wrapping byte write
// address and a saturating word count.
// Build option: define INSTR_ENCODER_ROUNDTRIP_CHECK_EN to add roundtrip_err_o,
// which decodes each output word again and flags any immediate that does not
// come back unchanged.
module instr_encoder #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                DEPTH_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [15:0]       count_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
    ,
    output logic              roundtrip_err_o
`endif
);

    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    // Address of the last memory word; the transfer of this word wraps to base.
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH_WORDS - 1));

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] word;
    logic [31:0] skid_word;
    logic        supported;
    logic        is_r;
    logic        imm_bad;
    logic        ready_en;
    logic        accept;
    logic        emit;
    logic        xfer;
    logic        load_new;
    logic        load_from_skid;
    logic        load_skid;

    // Build the instruction word for the presented bundle and classify it.
    always_comb begin
        word      = '0;
        supported = 1'b1;
        is_r      = 1'b0;
        case (opcode_i)
            OP_IALU, OP_LOAD: word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            OP_STORE:         word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            OP_BRANCH:        word = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                                      imm_i[3:0], imm_i[10], opcode_i};
            OP_RTYPE: begin
                word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                is_r = 1'b1;
            end
            default:          supported = 1'b0;
        endcase
    end

    // A signed value fits 12 bits when bits 31..11 are all copies of the sign.
    assign imm_bad = !is_r && !((&imm_i[31:11]) || (~|imm_i[31:11]));

    assign valid_o = (state != EMPTY);
    assign ready_o = ready_en && (state != FULL);
    assign accept  = valid_i && ready_o;
    assign emit    = accept && supported;
    assign xfer    = valid_o && ready_i;

    // Hold ready low until the first clock edge after reset is released.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= EMPTY;
        else        state <= next_state;
    end

    // Next state and load strobes for the output register and skid entry.
    always_comb begin
        next_state     = state;
        load_new       = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (emit) begin
                    next_state = LOADED;
                    load_new   = 1'b1;
                end
            end
            LOADED: begin
                if (xfer && emit) begin
                    load_new = 1'b1;
                end else if (xfer) begin
                    next_state = EMPTY;
                end else if (emit) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end
            end
            FULL: begin
                if (xfer) begin
                    next_state     = LOADED;
                    load_from_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Output register and skid entry data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_o   <= '0;
            skid_word <= '0;
        end else begin
            if (load_new)            instr_o <= word;
            else if (load_from_skid) instr_o <= skid_word;
            if (load_skid)           skid_word <= word;
        end
    end

    // Write address and word count advance on every downstream transfer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_o  <= BASE_ADDR;
            count_o <= '0;
        end else if (xfer) begin
            addr_o <= (addr_o == LAST_ADDR) ? BASE_ADDR : addr_o + ADDR_W'(4);
            if (count_o != 16'hFFFF) count_o <= count_o + 16'd1;
        end
    end

    // Sticky error flag; the code keeps the first cause, opcode beats range.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
        end else if (accept && (!supported || imm_bad)) begin
            err_o <= 1'b1;
            if (!err_o) err_code_o <= !supported ? 2'b10 : 2'b01;
        end
    end

`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
    logic [11:0] out_imm;
    logic [11:0] skid_imm;
    logic [11:0] rec_imm;
    logic        fresh;
    logic        check_en;

    // Track the requested immediate alongside each word and mark fresh loads.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_imm  <= '0;
            skid_imm <= '0;
            fresh    <= 1'b0;
        end else begin
            if (load_new)            out_imm <= imm_i[11:0];
            else if (load_from_skid) out_imm <= skid_imm;
            if (load_skid)           skid_imm <= imm_i[11:0];
            fresh <= load_new || load_from_skid;
        end
    end

    // Recover the immediate exactly as the core's decoder extracts it.
    always_comb begin
        rec_imm  = '0;
        check_en = 1'b1;
        case (instr_o[6:0])
            OP_IALU, OP_LOAD: rec_imm = instr_o[31:20];
            OP_STORE:         rec_imm = {instr_o[31:25], instr_o[11:7]};
            OP_BRANCH:        rec_imm = {instr_o[31], instr_o[7], instr_o[30:25], instr_o[11:8]};
            default:          check_en = 1'b0;
        endcase
    end

    // Compare sign-extended immediates in the cycle the word first appears.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            roundtrip_err_o <= 1'b0;
        end else if (fresh && check_en &&
                     ({{20{rec_imm[11]}}, rec_imm} != {{20{out_imm[11]}}, out_imm})) begin
            roundtrip_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's immediate sign-extend/decode path: packs decoded fields (opcode, registers, funct, 12-bit immediate) into 32-bit RV32I instruction words.
- Sits between the test/loader front end and instruction memory.
- Streams encoded words out with a valid/ready handshake and a running write address, so instruction memory can be filled sequentially.
- Immediate layouts are the exact inverse of the core's decoder: decode(encode(x)) returns the original imm.

Parameters:
- ADDR_W, 32, width of write address output.
- BASE_ADDR, 0, address of the first word after reset.
- DEPTH_WORDS, 256, number of words in the target memory; address wraps after DEPTH_WORDS words.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  field bundle valid.
- ready_o  out  1  encoder can accept a bundle.
- opcode_i  in  7  opcode: 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 0110011 R-type.
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- funct3_i  in  3  funct3.
- funct7_i  in  7  funct7 (R-type only).
- imm_i  in  32  signed immediate. Branch immediate is in the decoder's 12-bit halfword-offset units.
- valid_o  out  1  encoded word valid.
- ready_i  in  1  downstream accepts word.
- instr_o  out  32  encoded instruction word.
- addr_o  out  ADDR_W  byte address of instr_o.
- count_o  out  16  words emitted since reset, saturating at 0xFFFF.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  first error cause: 01 = imm out of range, 10 = unsupported opcode.

Behaviour:
- Reset (async, rst_i=0) values:
  - valid_o=0, instr_o=0, addr_o=BASE_ADDR, count_o=0, err_o=0, err_code_o=0.
  - ready_o=0 while rst_i is low; ready_o=1 from the first clock edge after release.
  - Any in-flight word is discarded.
- Datapath structure: a single output register stage plus one skid entry. Latency from accept to valid_o is 1 cycle.
- Input acceptance:
  - A bundle is accepted on a clock edge where valid_i and ready_o are both 1.
  - ready_o=0 only when the skid entry is occupied.
- Output handshake:
  - A word transfers on a clock edge where valid_o and ready_i are both 1.
  - instr_o and addr_o hold stable while valid_o=1 and ready_i=0.
- State machine:
  - EMPTY: output register free. Accept → LOADED.
  - LOADED: output register full. Transfer without accept → EMPTY. Accept without transfer → FULL (bundle goes to skid). Simultaneous accept and transfer → stay in LOADED with the new word.
  - FULL: output and skid both full, ready_o=0. Transfer moves skid into the output register → LOADED.
- Encoding:
  - I-type / load: {imm[11:0], rs1, funct3, rd, opcode}.
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Branch (imm = halfword offset h): inst[31]=h[11], inst[30:25]=h[9:4], inst[11:8]=h[3:0], inst[7]=h[10]; rs2, rs1, funct3 at their standard positions.
  - R-type: {funct7, rs2, rs1, funct3, rd, opcode}; imm_i is ignored.
- Range check (all non-R formats): imm_i must be in -2048..2047.
  - If out of range: the word is still emitted using imm_i[11:0], and the error is flagged with code 01.
- Unsupported opcode: the bundle is accepted and dropped. No word is emitted, address and count do not advance, and the error is flagged with code 10.
- Error flag rules:
  - err_o is sticky until reset.
  - err_code_o latches the first cause only.
  - If both conditions occur on one accept, code 10 wins.
- Address and count:
  - addr_o advances by 4 on each transfer.
  - After the word at BASE_ADDR+4*(DEPTH_WORDS-1) transfers, addr_o returns to BASE_ADDR.
  - count_o increments on each transfer and saturates at 0xFFFF.
- Reset asserted mid-transfer: the word is lost and no partial state remains.

Optional Feature:
- Macro: INSTR_ENCODER_ROUNDTRIP_CHECK_EN.
- Defined:
  - Adds an internal decoder of the output-register word, reproducing the core's immediate extraction.
  - For each non-R word, a mismatch between the recovered sign-extended 12-bit imm and imm_i[11:0] sign-extended sets an additional sticky output roundtrip_err_o (1 bit, reset 0).
  - Checking happens in the cycle valid_o first rises for that word.
- Undefined: port roundtrip_err_o is absent and no checker logic is present.

Test Plan:
- addi x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=0, imm=5), ready_i=1 → next cycle valid_o=1, instr_o=0x00500093, addr_o=BASE_ADDR, then count_o=1.
- sw x2,8(x1) (0100011, f3=010, rs1=1, rs2=2, imm=8) → instr_o=0x0020A423; R-type add x3,x1,x2 (0110011, f7=0) → 0x002081B3.
- beq x1,x2,imm=-4 (halfword, i.e. -8 bytes) → instr_o=0xFE208CE3; the decoder returns imm 0xFFFFFFFC.
- Backpressure: ready_i=0, push 3 back-to-back bundles → ready_o falls after the 2nd accept. Release ready_i → words emerge in order at addresses +0, +4, +8 with no loss or duplication.
- imm=2048 on addi → word emitted with imm field 0x800, err_o=1, err_code_o=01. A later opcode 1111111 is dropped; err_code_o stays 01 and count_o does not change.
- DEPTH_WORDS=4: stream 5 words → addr_o sequence 0, 4, 8, 12, 0. Assert rst_i=0 while valid_o=1 → all outputs immediately return to their reset values.
